// File: rtl/nand_unit_arbiter.sv
// Four-requester arbiter sharing one N-bit NAND-built bitwise unit (NAND2/NAND3/AND/NOT).
// Define NAND_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.

module nand2_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   assign y = ~(a & b);
endmodule

module nand3_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   output logic [N-1:0] y
);
   assign y = ~(a & b & c);
endmodule

module nand_unit_arbiter #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     req_valid,
   output logic [3:0]     req_ready,
   input  logic [7:0]     req_op,
   input  logic [4*N-1:0] req_a,
   input  logic [4*N-1:0] req_b,
   input  logic [4*N-1:0] req_c,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [1:0]     resp_id,
   output logic [N-1:0]   resp_data,
   output logic           busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]   state;
   logic [1:0]   search_base;
   logic [1:0]   cand;
   logic [1:0]   grant_id;
   logic         grant_found;
   logic [1:0]   op_q;
   logic [1:0]   id_q;
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic [N-1:0] c_q;
   logic [N-1:0] nand_ab;
   logic [N-1:0] nand_abc;
   logic [N-1:0] and_ab;
   logic [N-1:0] not_a;
   logic [N-1:0] unit_out;

`ifdef NAND_ARB_FIXED_PRIO_EN
   assign search_base = 2'd0;
`else
   logic [1:0] rr_ptr;

   // The pointer moves just past the winner so every requester gets a turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 2'd0;
      end else if (state == IDLE && grant_found) begin
         rr_ptr <= grant_id + 2'd1;
      end
   end

   assign search_base = rr_ptr;
`endif

   // First valid requester at or after the search base, wrapping modulo 4.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = 2'd0;
      cand        = 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = search_base + k[1:0];
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   always_comb begin
      req_ready = 4'b0000;
      if (!rst && state == IDLE && grant_found) begin
         req_ready = 4'b0001 << grant_id;
      end
   end

   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   nand2_nbit #(.N(N)) u_nand_ab (.a(a_q), .b(b_q), .y(nand_ab));
   nand3_nbit #(.N(N)) u_nand_abc (.a(a_q), .b(b_q), .c(c_q), .y(nand_abc));
   nand2_nbit #(.N(N)) u_and_ab (.a(nand_ab), .b(nand_ab), .y(and_ab));
   nand2_nbit #(.N(N)) u_not_a (.a(a_q), .b(a_q), .y(not_a));

   always_comb begin
      unit_out = not_a;
      case (op_q)
         2'b00:   unit_out = nand_ab;
         2'b01:   unit_out = nand_abc;
         2'b10:   unit_out = and_ab;
         default: unit_out = not_a;
      endcase
   end

   // Operands are captured only for the granted requester; the result is registered out of EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= 2'd0;
         id_q      <= 2'd0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         resp_id   <= 2'd0;
         resp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  op_q  <= req_op[grant_id*2 +: 2];
                  a_q   <= req_a[grant_id*N +: N];
                  b_q   <= req_b[grant_id*N +: N];
                  c_q   <= req_c[grant_id*N +: N];
                  id_q  <= grant_id;
                  state <= EXEC;
               end
            end
            EXEC: begin
               resp_data <= unit_out;
               resp_id   <= id_q;
               state     <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Randomized self-checking bench for nand_unit_arbiter (N=4) against a transaction-level model.
// Honours NAND_ARB_FIXED_PRIO_EN in its grant model.

module tb_nand_unit_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req_valid;
   logic [3:0]     req_ready;
   logic [7:0]     req_op;
   logic [4*N-1:0] req_a;
   logic [4*N-1:0] req_b;
   logic [4*N-1:0] req_c;
   logic           resp_valid;
   logic           resp_ready;
   logic [1:0]     resp_id;
   logic [N-1:0]   resp_data;
   logic           busy;

   logic [1:0]   op_v [4];
   logic [N-1:0] a_v  [4];
   logic [N-1:0] b_v  [4];
   logic [N-1:0] c_v  [4];

   int ptr;
   int total;
   int passed;

   always #5 clk = ~clk;

   nand_unit_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end else begin
         passed++;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] vld);
      req_valid = vld;
      for (int i = 0; i < 4; i++) begin
         req_op[2*i +: 2] = op_v[i];
         req_a[N*i +: N]  = a_v[i];
         req_b[N*i +: N]  = b_v[i];
         req_c[N*i +: N]  = c_v[i];
      end
   endtask

   task automatic randomizeOperands();
      for (int i = 0; i < 4; i++) begin
         op_v[i] = 2'($urandom);
         a_v[i]  = N'($urandom);
         b_v[i]  = N'($urandom);
         c_v[i]  = N'($urandom);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Result expressed as complements against the all-ones mask.
   function automatic logic [N-1:0] refResult(input logic [1:0] op, input logic [N-1:0] a,
                                              input logic [N-1:0] b, input logic [N-1:0] c);
      int mask;
      mask = (1 << N) - 1;
      case (op)
         2'b00:   return N'(mask - int'(a & b));
         2'b01:   return N'(mask - int'(a & b & c));
         2'b10:   return a & b;
         default: return N'(mask - int'(a));
      endcase
   endfunction

   function automatic int refGrant(input logic [3:0] vld);
`ifdef NAND_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (vld[i]) return i;
`else
      for (int k = 0; k < 4; k++) if (vld[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
      return -1;
   endfunction

   // One full transaction (or one idle cycle when nothing is requested), with 'stall' cycles of backpressure.
   task automatic runTxn(input logic [3:0] vld, input int stall);
      int           g;
      logic [N-1:0] exp_d;
      logic [3:0]   exp_rdy;
      applyStimulus(vld);
      resp_ready = 1'($urandom);
      #1;
      g = refGrant(vld);
      if (g < 0) begin
         checkOutput("idle_ready", req_ready, 0);
         checkOutput("idle_busy", busy, 0);
         checkOutput("idle_rvalid", resp_valid, 0);
         stepCycle();
         return;
      end
      exp_d   = refResult(op_v[g], a_v[g], b_v[g], c_v[g]);
      exp_rdy = 4'(1 << g);
      checkOutput("grant", req_ready, exp_rdy);
      checkOutput("accept_busy", busy, 0);
      checkOutput("accept_rvalid", resp_valid, 0);
      stepCycle();
      ptr = (g + 1) % 4;
      randomizeOperands();
      applyStimulus(4'($urandom));
      #1;
      checkOutput("exec_ready", req_ready, 0);
      checkOutput("exec_busy", busy, 1);
      checkOutput("exec_rvalid", resp_valid, 0);
      stepCycle();
      resp_ready = (stall == 0);
      randomizeOperands();
      applyStimulus(4'($urandom));
      #1;
      checkOutput("resp_valid", resp_valid, 1);
      checkOutput("resp_data", resp_data, exp_d);
      checkOutput("resp_id", resp_id, g);
      checkOutput("resp_ready_out", req_ready, 0);
      for (int s = 0; s < stall; s++) begin
         stepCycle();
         checkOutput("hold_valid", resp_valid, 1);
         checkOutput("hold_data", resp_data, exp_d);
         checkOutput("hold_id", resp_id, g);
         checkOutput("hold_ready_out", req_ready, 0);
      end
      resp_ready = 1'b1;
      stepCycle();
      applyStimulus(4'b0000);
      resp_ready = 1'b0;
      #1;
      checkOutput("back_idle_rvalid", resp_valid, 0);
      checkOutput("back_idle_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int g;
      total  = 0;
      passed = 0;
      ptr    = 0;
      randomizeOperands();
      applyStimulus(4'b1111);
      resp_ready = 1'b0;
      rst = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("rst_ready", req_ready, 0);
      checkOutput("rst_rvalid", resp_valid, 0);
      checkOutput("rst_data", resp_data, 0);
      checkOutput("rst_id", resp_id, 0);
      checkOutput("rst_busy", busy, 0);
      applyStimulus(4'b0000);
      rst = 1'b0;
      stepCycle();

      op_v[0] = 2'b01; a_v[0] = 4'b1011; b_v[0] = 4'b1110; c_v[0] = 4'b1101;
      runTxn(4'b0001, 0);

      op_v[2] = 2'b10; a_v[2] = 4'b1010; b_v[2] = 4'b1100;
      runTxn(4'b0100, 0);
      op_v[1] = 2'b11; a_v[1] = 4'b0101;
      runTxn(4'b0010, 0);
      op_v[3] = 2'b00; a_v[3] = 4'b1111; b_v[3] = 4'b0000;
      runTxn(4'b1000, 0);

      for (int i = 0; i < 5; i++) begin
         randomizeOperands();
         runTxn(4'b1111, 0);
      end

      randomizeOperands();
      runTxn(4'b0110, 5);

      // Reset while the granted request is in EXEC: it must vanish without a response.
      randomizeOperands();
      applyStimulus(4'b0110);
      #1;
      g = refGrant(4'b0110);
      checkOutput("midrst_grant", req_ready, 4'(1 << g));
      stepCycle();
      applyStimulus(4'b1111);
      rst = 1'b1;
      #1;
      checkOutput("midrst_exec_busy", busy, 1);
      stepCycle();
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_rvalid", resp_valid, 0);
      checkOutput("midrst_ready", req_ready, 0);
      applyStimulus(4'b0000);
      rst = 1'b0;
      ptr = 0;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("post_rst_rvalid", resp_valid, 0);
      end
      randomizeOperands();
      runTxn(4'b1111, 0);

      for (int i = 0; i < 40; i++) begin
         randomizeOperands();
         runTxn(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom), $urandom_range(0, 3));
      end

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
